// File: rtl/mux8_to_1_gate_pkg.sv
// Shared constants for the gate-level 8-to-1 multiplexer slice.
package mux_pkg;
  localparam int N_IN  = 8;
  localparam int SEL_W = 3;
endpackage

// File: rtl/mux8_to_1_gate_if.sv
// Signal bundle for the 8-to-1 gate mux: data, selects, combinational and registered output.
// No handshake: there is no valid/ready pair; y is meaningful whenever the inputs are
// stable, and y_q holds the y value captured at the previous rising clk edge.
interface mux8_to_1_gate_if;
  logic i0, i1, i2, i3, i4, i5, i6, i7;
  logic s0, s1, s2;
  logic y;
  logic y_q;

  modport master (
    output i0, i1, i2, i3, i4, i5, i6, i7,
    output s0, s1, s2,
    input  y, y_q
  );

  modport slave (
    input  i0, i1, i2, i3, i4, i5, i6, i7,
    input  s0, s1, s2,
    output y, y_q
  );
endinterface

// File: rtl/mux8_to_1_gate_decoder.sv
// 3-to-8 one-hot decoder built only from NOT and 3-input AND primitives.
module decoder3x8_gate
  import mux_pkg::*;
(
  input  wire            s2,
  input  wire            s1,
  input  wire            s0,
  output wire [N_IN-1:0] d
);
  wire ns0, ns1, ns2;

  not g_ns0 (ns0, s0);
  not g_ns1 (ns1, s1);
  not g_ns2 (ns2, s2);

  // Minterm K is high exactly when {s2,s1,s0} == K.
  and g_d0 (d[0], ns2, ns1, ns0);
  and g_d1 (d[1], ns2, ns1, s0);
  and g_d2 (d[2], ns2, s1,  ns0);
  and g_d3 (d[3], ns2, s1,  s0);
  and g_d4 (d[4], s2,  ns1, ns0);
  and g_d5 (d[5], s2,  ns1, s0);
  and g_d6 (d[6], s2,  s1,  ns0);
  and g_d7 (d[7], s2,  s1,  s0);
endmodule

// File: rtl/mux8_to_1_gate.sv
// Gate-level 8-to-1 single-bit mux (decoder, AND plane, OR) plus a registered output copy.
module mux8_to_1_gate
  import mux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mux8_to_1_gate_if.slave   bus
);
  wire [N_IN-1:0] d;
  wire [N_IN-1:0] t;
  wire            y_c;

  decoder3x8_gate u_dec (
    .s2 (bus.s2),
    .s1 (bus.s1),
    .s0 (bus.s0),
    .d  (d)
  );

  and g_t0 (t[0], bus.i0, d[0]);
  and g_t1 (t[1], bus.i1, d[1]);
  and g_t2 (t[2], bus.i2, d[2]);
  and g_t3 (t[3], bus.i3, d[3]);
  and g_t4 (t[4], bus.i4, d[4]);
  and g_t5 (t[5], bus.i5, d[5]);
  and g_t6 (t[6], bus.i6, d[6]);
  and g_t7 (t[7], bus.i7, d[7]);

  // Only one term can be high since the decode is one-hot, so a plain OR merges them.
  or g_or (y_c, t[0], t[1], t[2], t[3], t[4], t[5], t[6], t[7]);

  assign bus.y = y_c;

  always_ff @(posedge clk) begin
    if (rst) bus.y_q <= 1'b0;
    else     bus.y_q <= y_c;
  end
endmodule

// File: tb/tb_mux8_to_1_gate.sv
// Self-checking bench for mux8_to_1_gate: directed sweeps, reset sequences and random traffic.
module tb_mux8_to_1_gate;
  import mux_pkg::*;

  logic clk;
  logic rst;
  mux8_to_1_gate_if bus ();

  mux8_to_1_gate dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [0:0] exp_q[$];
  logic [0:0] exp_yq_q[$];
  logic       last_yq;
  int         n_checks = 0;
  int         n_errors = 0;
  event       y_ev;

  function automatic logic ref_mux(input logic [N_IN-1:0] data, input int sel);
    return ((data >> sel) & 1) != 0;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at time %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_in(input logic [N_IN-1:0] data, input logic [SEL_W-1:0] sel);
    {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0} = data;
    {bus.s2, bus.s1, bus.s0} = sel;
  endtask

  task automatic comb_step(input logic [N_IN-1:0] data, input logic [SEL_W-1:0] sel);
    set_in(data, sel);
    exp_q.push_back(ref_mux(data, int'(sel)));
    -> y_ev;
    #10;
  endtask

  task automatic clk_step(input logic r, input logic [N_IN-1:0] data, input logic [SEL_W-1:0] sel);
    @(negedge clk);
    rst = r;
    set_in(data, sel);
    #1;
    check("y_q_hold_between_edges", bus.y_q, last_yq);
    exp_q.push_back(ref_mux(data, int'(sel)));
    -> y_ev;
    last_yq = r ? 1'b0 : ref_mux(data, int'(sel));
    exp_yq_q.push_back(last_yq);
    @(posedge clk);
  endtask

  // monitors: combinational y after each stimulus, y_q after each edge with a pending expectation
  initial begin
    forever begin
      @(y_ev);
      #1;
      if (exp_q.size() > 0) check("y", bus.y, exp_q.pop_front());
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (exp_yq_q.size() > 0) begin
        #1;
        check("y_q", bus.y_q, exp_yq_q.pop_front());
      end
    end
  end

  initial begin
    logic [N_IN-1:0] data;
    rst = 1'b1;
    last_yq = 1'b0;
    set_in('0, '0);
    #20;

    // alternating pattern sweep
    for (int s = 0; s < N_IN; s++) comb_step(8'b10101010, SEL_W'(s));

    // walking one: y high only when sel matches the hot position
    for (int k = 0; k < N_IN; k++)
      for (int s = 0; s < N_IN; s++) comb_step(8'(1 << k), SEL_W'(s));

    // sel = 5: i5 is followed, other inputs are ignored
    comb_step(8'b00000000, 3'd5);
    comb_step(8'b00100000, 3'd5);
    comb_step(8'b00000000, 3'd5);
    comb_step(8'b11011111, 3'd5);
    comb_step(8'b00100000, 3'd5);

    // clocked run: reset, release, reselect
    last_yq = bus.y_q;
    clk_step(1'b1, 8'b10101010, 3'd0);
    clk_step(1'b1, 8'b10101010, 3'd0);
    clk_step(1'b0, 8'b10101010, 3'd3);
    clk_step(1'b0, 8'b10101010, 3'd4);
    clk_step(1'b0, 8'b10101010, 3'd7);
    // mid-stream reset: y keeps muxing, y_q forced low
    clk_step(1'b1, 8'b10101010, 3'd7);
    clk_step(1'b1, 8'b10101010, 3'd5);
    clk_step(1'b0, 8'b10101010, 3'd7);

    // random clocked traffic with occasional reset
    for (int n = 0; n < 60; n++) begin
      data = 8'($urandom);
      clk_step($urandom_range(0, 7) == 0, data, SEL_W'($urandom_range(0, 7)));
    end

    // random combinational traffic
    for (int n = 0; n < 40; n++) comb_step(8'($urandom), SEL_W'($urandom_range(0, 7)));

    // drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 20 && (exp_q.size() > 0 || exp_yq_q.size() > 0); k++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() > 0 || exp_yq_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: pending y=%0d y_q=%0d expected 0", exp_q.size(), exp_yq_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mux8_to_1_gate.md
# mux8_to_1_gate

Gate-level 8-to-1 single-bit multiplexer with a registered copy of its output. Three select bits (s2 is the MSB) choose one of eight scalar data inputs. The combinational path `y` is built only from primitive gates: NOT, AND and OR. A flip-flop stage `y_q` provides a clocked version for synchronous consumers. The block is a leaf datapath element in the selection/steering logic.

## Interface
- Parameters: none. Widths are fixed at 8 data inputs and 3 select bits.
- `clk`  input  1  system clock; rising-edge active.
- `rst`  input  1  reset; synchronous and active-high.
- `i0`..`i7`  input  1 each  data inputs; `iK` is selected when {s2,s1,s0} == K.
- `s0`  input  1  select LSB.
- `s1`  input  1  select middle bit.
- `s2`  input  1  select MSB.
- `y`  output  1  combinational selected data bit.
- `y_q`  output  1  registered `y`.

## Operation
- Select index: sel = {s2,s1,s0}, range 0..7.
- Combinational output: y = i[sel].
- Gate-level realisation:
  - inverted selects: ns0, ns1, ns2;
  - eight 3-input AND minterms, dK = sel decode of K;
  - eight 2-input ANDs: tK = iK & dK;
  - one 8-input OR, or a balanced OR tree, drives `y`.
- Exactly one dK is 1 for any known select value.
- No behavioural `?:`, `case` or array indexing is used in the combinational path.
- Register: on each rising `clk` edge, `y_q` <= 0 if `rst`, else `y`.
- X/Z on a select bit: the output follows gate-primitive X propagation. No special handling.

## Timing
- `y` has zero-cycle latency. It responds within the same delta/time step to any change on iK or sK.
- `y_q` has one-cycle latency. It reflects the `y` value sampled at the previous rising edge.
- Reset value: `y_q` = 0. `y` is purely combinational and is unaffected by `rst`.
- Reset is sampled only at a clock edge:
  - asserting `rst` between edges does not change `y_q` until the next edge;
  - deasserting `rst` means `y` is captured at the first edge where `rst` = 0.
- Reset asserted during select activity: `y` keeps muxing normally; `y_q` holds 0 while `rst` = 1.
- Simultaneous select and data change: `y` settles to the new i[new sel]; `y_q` captures the settled value at the next edge.

## Structure
- Shared package `mux_pkg`:
  - constant N_IN = 8;
  - constant SEL_W = 3.
- Natural sub-module: `decoder3x8_gate`.
  - Inputs: s2, s1, s0.
  - Output: one-hot d[7:0], built from NOT/AND primitives.
- The top level instantiates the decoder, the eight AND gates, the OR tree and the output flip-flop.

## Test plan
- Data = 8'b10101010 (i0 = 0 … i7 = 1). Sweep sel 0→7, 10 time units per step, no clock needed. Required `y` sequence: 0,1,0,1,0,1,0,1.
- Data = 8'b00000001. Sweep sel 0..7 → `y` = 1 only at sel 0. Repeat with a walking one at each position K → `y` = 1 only when sel == K (one-hot decode check).
- Hold sel = 5 and toggle i5 0→1→0 → `y` follows immediately. Toggling any other iK leaves `y` unchanged.
- Clocked run, data 8'b10101010, rst = 1 for 2 cycles → `y_q` = 0. Release rst with sel = 3 → `y_q` = 1 after the first edge. Change sel to 4 → `y_q` = 0 one edge later.
- Assert rst mid-stream with sel = 7 (y = 1) → `y_q` = 0 at the next edge, while `y` stays 1. Deassert rst → `y_q` = 1 at the following edge.
